// File: rtl/spe_pkg.sv
// Shared definitions for the SPE instruction-fetch slice.
//   LS_AW     : local-store quadword address width
//   INST_W    : instruction width
//   QW_W      : local-store read width (one quadword = 4 instructions)
//   PC_W      : byte PC width
//   TAKE_*    : decode consume-count encoding
//   fetch_st_e: request FSM states
package spe_pkg;
  localparam int LS_AW  = 14;
  localparam int INST_W = 32;
  localparam int QW_W   = 128;
  localparam int PC_W   = LS_AW + 4;

  localparam logic [1:0] TAKE_NONE = 2'd0;
  localparam logic [1:0] TAKE_ONE  = 2'd1;
  localparam logic [1:0] TAKE_TWO  = 2'd2;

  typedef enum logic [1:0] {
    FS_IDLE,  // nothing in flight, waiting for buffer room
    FS_REQ,   // ls_req held high until granted
    FS_WAIT   // one request granted, response pending
  } fetch_st_e;
endpackage

// File: rtl/spe_ifetch_if.sv
// Fetch-stage bundle: local-store request/response channel plus the
// decode-side issue/consume/redirect signals.
//   master : the fetch stage (drives ls_req/ls_addr and the issue outputs)
//   slave  : local store + decode (drives grant/response, take, redirect)
interface spe_ifetch_if #(
  parameter int LS_AW = spe_pkg::LS_AW
);
  import spe_pkg::*;
  localparam int PCW = LS_AW + 4;

  logic              ls_req;
  logic [LS_AW-1:0]  ls_addr;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [QW_W-1:0]   ls_rdata;
  logic [INST_W-1:0] inst0;
  logic [INST_W-1:0] inst1;
  logic [PCW-1:0]    pc0;
  logic [1:0]        inst_vld;
  logic [1:0]        dec_take;
  logic              redirect;
  logic [PCW-1:0]    redirect_pc;

  modport master (
    output ls_req, ls_addr, inst0, inst1, pc0, inst_vld,
    input  ls_gnt, ls_rvalid, ls_rdata, dec_take, redirect, redirect_pc
  );
  modport slave (
    input  ls_req, ls_addr, inst0, inst1, pc0, inst_vld,
    output ls_gnt, ls_rvalid, ls_rdata, dec_take, redirect, redirect_pc
  );
endinterface

// File: rtl/spe_ibuf.sv
// Instruction word FIFO.
//   flush_i    : empty the buffer (wins over write and read)
//   wr_en_i    : write one quadword, words wr_first_i..3 (word 0 = MSBs)
//   rd_n_i     : words consumed from the head this cycle (0..2)
//   rd0_o/rd1_o: head and head+1 words, zero when not valid
//   vld_o      : {occ>=2, occ>=1}
//   occ_nxt_o  : occupancy after this cycle's flush/write/read
// Depth is 4*IBUF_QW and must be a power of two so pointers wrap freely.
module spe_ibuf import spe_pkg::*; #(
  parameter int IBUF_QW = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           wr_en_i,
  input  logic [1:0]                     wr_first_i,
  input  logic [QW_W-1:0]                wr_qw_i,
  input  logic [1:0]                     rd_n_i,
  output logic [INST_W-1:0]              rd0_o,
  output logic [INST_W-1:0]              rd1_o,
  output logic [1:0]                     vld_o,
  output logic [$clog2(4*IBUF_QW+1)-1:0] occ_nxt_o
);
  localparam int DEPTH = 4 * IBUF_QW;
  localparam int PW    = $clog2(DEPTH);
  localparam int OW    = $clog2(DEPTH + 1);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     hd_q, tl_q;
  logic [OW-1:0]     occ_q;
  logic [2:0]        wcnt;

  assign wcnt      = wr_en_i ? (3'd4 - {1'b0, wr_first_i}) : 3'd0;
  assign occ_nxt_o = flush_i ? '0 : (occ_q + OW'(wcnt) - OW'(rd_n_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hd_q  <= '0;
      tl_q  <= '0;
      occ_q <= '0;
    end else if (flush_i) begin
      hd_q  <= '0;
      tl_q  <= '0;
      occ_q <= '0;
    end else begin
      hd_q  <= hd_q + PW'(rd_n_i);
      tl_q  <= tl_q + PW'(wcnt);
      occ_q <= occ_nxt_o;
    end
  end

  // Leading skipped words are squeezed out: word i lands at tail+(i-first).
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= int'(wr_first_i))
          mem_q[tl_q + PW'(i - int'(wr_first_i))] <= wr_qw_i[QW_W-1-INST_W*i -: INST_W];
      end
    end
  end

  assign vld_o = {occ_q >= OW'(2), occ_q >= OW'(1)};
  assign rd0_o = vld_o[0] ? mem_q[hd_q] : '0;
  assign rd1_o = vld_o[1] ? mem_q[hd_q + PW'(1)] : '0;
endmodule

// File: rtl/spe_ifetch.sv
// SPE instruction fetch stage.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : spe_ifetch_if.master
//     ls_req/ls_addr  registered quadword fetch request, held until ls_gnt
//     ls_rvalid/rdata in-order response, one per grant
//     inst0/inst1/pc0/inst_vld  up to two sequential instructions to decode
//     dec_take        words consumed by decode this cycle
//     redirect/_pc    flush and restart fetch at a new byte PC
module spe_ifetch #(
  parameter int LS_AW   = spe_pkg::LS_AW,
  parameter int IBUF_QW = 2
) (
  input logic          clk,
  input logic          rst,
  spe_ifetch_if.master bus
);
  import spe_pkg::*;

  localparam int PCW = LS_AW + 4;
  localparam int CAP = 4 * IBUF_QW;
  localparam int OW  = $clog2(CAP + 1);

  fetch_st_e        state_q;
  logic             st_q;     // in-flight response belongs to a dead stream
  logic [LS_AW-1:0] fa_q;     // next quadword to request
  logic [LS_AW-1:0] addr_q;
  logic [1:0]       sk_q;     // leading words to drop from next live response
  logic [PCW-1:0]   pc_q;     // byte PC of buffer head

  logic [OW-1:0]    occ_nxt;
  logic [1:0]       take;
  logic             wr_en, room, busy_after;
  logic [LS_AW-1:0] r_fa;
  logic [PCW-1:0]   r_pc;
  logic             unused_pc_lsb;

  assign take  = bus.redirect ? TAKE_NONE : bus.dec_take;
  assign wr_en = bus.ls_rvalid && (state_q == FS_WAIT) && !st_q && !bus.redirect;
  // Room for a full quadword once this cycle's write/read have settled.
  assign room  = (occ_nxt <= OW'(CAP - 4));
  // A request is still owed a response after this cycle: granted now, or
  // granted earlier and not answered this cycle.
  assign busy_after = ((state_q == FS_REQ) && bus.ls_gnt) ||
                      ((state_q == FS_WAIT) && !bus.ls_rvalid);

  assign r_fa          = bus.redirect_pc[PCW-1:4];
  assign r_pc          = {bus.redirect_pc[PCW-1:2], 2'b00};
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

  spe_ibuf #(.IBUF_QW(IBUF_QW)) u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.redirect),
    .wr_en_i    (wr_en),
    .wr_first_i (sk_q),
    .wr_qw_i    (bus.ls_rdata),
    .rd_n_i     (take),
    .rd0_o      (bus.inst0),
    .rd1_o      (bus.inst1),
    .vld_o      (bus.inst_vld),
    .occ_nxt_o  (occ_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FS_IDLE;
      st_q    <= 1'b0;
      fa_q    <= '0;
      addr_q  <= '0;
      sk_q    <= '0;
      pc_q    <= '0;
    end else if (bus.redirect) begin
      fa_q <= r_fa;
      sk_q <= bus.redirect_pc[3:2];
      pc_q <= r_pc;
      if (busy_after) begin
        // Let the old response drain; fetch restarts from fa_q when it lands.
        state_q <= FS_WAIT;
        st_q    <= 1'b1;
      end else begin
        // Buffer is flushed so there is always room; an ungranted request
        // is simply retargeted.
        state_q <= FS_REQ;
        st_q    <= 1'b0;
        addr_q  <= r_fa;
      end
    end else begin
      pc_q <= pc_q + (PCW'(take) << 2);
      unique case (state_q)
        FS_IDLE: begin
          if (room) begin
            state_q <= FS_REQ;
            addr_q  <= fa_q;
          end
        end
        FS_REQ: begin
          if (bus.ls_gnt) begin
            state_q <= FS_WAIT;
            fa_q    <= fa_q + LS_AW'(1);
          end
        end
        FS_WAIT: begin
          if (bus.ls_rvalid) begin
            st_q <= 1'b0;
            if (!st_q) sk_q <= '0;
            if (room) begin
              state_q <= FS_REQ;
              addr_q  <= fa_q;
            end else begin
              state_q <= FS_IDLE;
            end
          end
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  assign bus.ls_req  = (state_q == FS_REQ);
  assign bus.ls_addr = addr_q;
  assign bus.pc0     = pc_q;
endmodule

// File: tb/tb_spe_ifetch.sv
module tb_spe_ifetch;
  import spe_pkg::*;

  localparam int AW = spe_pkg::LS_AW;
  localparam int PW = AW + 4;
  localparam int TM_RAND = 0, TM_MAX = 1, TM_HOLD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spe_ifetch_if #(.LS_AW(AW)) bus ();
  spe_ifetch #(.LS_AW(AW), .IBUF_QW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0, bad = 0;
  int consumed = 0, ngrant = 0;
  int take_mode = TM_MAX;
  int gnt_pct = 100, lat_min = 2, lat_max = 2;
  bit gnt_hold = 0, busy = 0, live = 0;
  int cnt = 0;
  logic [AW-1:0] baddr;

  // Expected issue order: byte PCs of the instruction stream from the head.
  logic [PW-1:0] expq[$];
  logic [PW-1:0] nxt;

  function automatic logic [31:0] wd(logic [PW-1:0] p);
    return 32'hA5A0_0000 ^ 32'(p);
  endfunction

  function automatic logic [127:0] qw(logic [AW-1:0] a);
    logic [PW-1:0] b;
    b = {a, 4'h0};
    return {wd(b), wd(b + PW'(4)), wd(b + PW'(8)), wd(b + PW'(12))};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (expq.size() < 8) begin
      expq.push_back(nxt);
      nxt = nxt + PW'(4);
    end
  endtask

  task automatic restart(logic [PW-1:0] p);
    expq.delete();
    nxt = {p[PW-1:2], 2'b00};
    topup();
  endtask

  task automatic cyc(int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic do_redirect(logic [PW-1:0] p);
    bus.redirect    = 1'b1;
    bus.redirect_pc = p;
    restart(p);
    cyc(1);
    bus.redirect = 1'b0;
  endtask

  // Decode: consume a random or maximal legal count.
  initial begin
    int nv;
    bus.dec_take = 2'd0;
    forever begin
      @(negedge clk); #1;
      nv = bus.inst_vld[1] ? 2 : (bus.inst_vld[0] ? 1 : 0);
      if (take_mode == TM_HOLD) bus.dec_take = 2'd0;
      else if (take_mode == TM_MAX) bus.dec_take = 2'(nv);
      else bus.dec_take = 2'($urandom_range(0, nv));
    end
  end

  // Local store: random grant delay, random latency, one outstanding.
  initial begin
    bus.ls_gnt = 1'b0; bus.ls_rvalid = 1'b0; bus.ls_rdata = '0;
    forever begin
      @(negedge clk); #1;
      bus.ls_gnt = 1'b0; bus.ls_rvalid = 1'b0;
      if (busy && live) chk("one_outstanding", bus.ls_req, 0);
      if (busy) begin
        if (cnt == 0) begin
          bus.ls_rvalid = 1'b1;
          bus.ls_rdata  = qw(baddr);
          busy = 0;
        end else cnt--;
      end else if (rst && bus.ls_req && !gnt_hold && $urandom_range(0, 99) < gnt_pct) begin
        bus.ls_gnt = 1'b1;
        baddr = bus.ls_addr;
        cnt   = $urandom_range(lat_min, lat_max) - 1;
        busy  = 1; live = 1;
        ngrant++;
      end
    end
  end

  // Monitor: retire consumed words at the edge, compare the head mid-cycle.
  initial begin
    bit after_rd;
    after_rd = 0;
    forever begin
      @(posedge clk);
      if (!rst) after_rd = 0;
      else if (bus.redirect) after_rd = 1;
      else begin
        after_rd = 0;
        for (int i = 0; i < int'(bus.dec_take); i++) void'(expq.pop_front());
        consumed += int'(bus.dec_take);
        topup();
      end
      @(negedge clk);
      if (rst) begin
        if (after_rd) chk("vld_after_redirect", bus.inst_vld, 0);
        else begin
          chk("vld_legal", bus.inst_vld == 2'b10, 0);
          if (bus.inst_vld[0]) begin
            chk("pc0", bus.pc0, expq[0]);
            chk("inst0", bus.inst0, wd(expq[0]));
          end
          if (bus.inst_vld[1]) chk("inst1", bus.inst1, wd(expq[1]));
        end
      end
    end
  end

  initial begin
    bit ok, ok2;
    int g0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    cyc(2);
    chk("rst_req", bus.ls_req, 0);
    chk("rst_addr", bus.ls_addr, 0);
    chk("rst_vld", bus.inst_vld, 0);
    chk("rst_inst0", bus.inst0, 0);
    chk("rst_inst1", bus.inst1, 0);
    chk("rst_pc0", bus.pc0, 0);
    restart('0);
    rst = 1'b1;

    // First fetch after reset targets quadword 0.
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin cyc(1); ok = bus.ls_req; end
    chk("first_req", ok, 1);
    chk("first_addr", bus.ls_addr, 0);
    cyc(40);

    // Decode stalls: buffer fills to 8 words and fetch stops.
    take_mode = TM_HOLD;
    cyc(30);
    g0 = ngrant;
    cyc(20);
    chk("full_no_grant", ngrant, g0);
    chk("full_req", bus.ls_req, 0);
    chk("full_vld", bus.inst_vld, 2'b11);

    // Redirect while idle into the middle of a quadword.
    do_redirect(18'h0000C);
    chk("ridle_req", bus.ls_req, 1);
    chk("ridle_addr", bus.ls_addr, 0);
    chk("ridle_vld", bus.inst_vld, 0);
    take_mode = TM_RAND;
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    cyc(60);

    // Redirect while a request is pending but not granted.
    gnt_hold = 1;
    cyc(10);
    do_redirect(18'h00123);
    chk("pend_req", bus.ls_req, 1);
    chk("pend_addr", bus.ls_addr, 14'h012);
    cyc(2);
    do_redirect(18'h002A7);
    chk("retgt_req", bus.ls_req, 1);
    chk("retgt_addr", bus.ls_addr, 14'h02A);
    gnt_hold = 0;
    cyc(40);

    // Redirect in the grant cycle, then one cycle after a grant.
    lat_min = 6; lat_max = 6;
    for (int v = 0; v < 2; v++) begin
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin cyc(1); ok = !busy; end
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin cyc(1); ok = busy; end
      chk("os_seen", ok, 1);
      if (v == 1) cyc(1);
      do_redirect(v == 0 ? 18'h001F4 : 18'h000F8);
      chk("stale_no_req", bus.ls_req, 0);
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin cyc(1); ok = bus.ls_req; end
      chk("stale_req", ok, 1);
      chk("stale_addr", bus.ls_addr, v == 0 ? 14'h01F : 14'h00F);
      cyc(30);
    end

    // Reset in the middle of a fetch; the late response must be ignored.
    lat_min = 5; lat_max = 5;
    do_redirect(18'h03440);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin cyc(1); ok = !busy; end
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin cyc(1); ok = busy; end
    chk("mid_os_seen", ok, 1);
    live = 0;
    rst = 1'b0;
    cyc(1);
    chk("mid_rst_vld", bus.inst_vld, 0);
    chk("mid_rst_req", bus.ls_req, 0);
    chk("mid_rst_pc0", bus.pc0, 0);
    cyc(1);
    restart('0);
    rst = 1'b1;
    lat_min = 1; lat_max = 4;
    cyc(40);

    // Sequential fetch across the top of local store.
    do_redirect({14'h3FFF, 4'h9});
    ok = 0; ok2 = 0;
    for (int i = 0; i < 60 && !(ok && ok2); i++) begin
      cyc(1);
      if (bus.ls_req && bus.ls_addr == '0) ok = 1;
      if (bus.inst_vld[0] && bus.pc0 == '0) ok2 = 1;
    end
    chk("wrap_addr0", ok, 1);
    chk("wrap_pc0", ok2, 1);

    // Random traffic with random redirects.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 3) == 0) do_redirect({14'h3FFF, 4'($urandom)});
        else do_redirect(18'($urandom));
      end else cyc(1);
    end
    chk("progress", consumed > 300, 1);
    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
